// File: rtl/burst_ram_arbiter_pkg.sv
// Shared types for burst_ram_arbiter: FSM states, owner index and a grant-vector helper.
package burst_ram_arbiter_pkg;

    localparam int NumRequesters = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WRITE = 2'd2,
        READ  = 2'd3
    } state_e;

    typedef logic [0:0] owner_t;

    function automatic logic [NumRequesters-1:0] owner_onehot(input owner_t o);
        logic [NumRequesters-1:0] v;
        v    = '0;
        v[o] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/burst_ram_arbiter.sv
// Two-master burst arbiter in front of one burst_ram (r0 = icache, r1 = dcache).
// Define BURST_RAM_ARBITER_FIXED_PRIORITY_EN to make r1 win every tie instead of round-robin.
module burst_ram_arbiter
    import burst_ram_arbiter_pkg::*;
#(
    parameter int AddressBitWidth = 4,
    parameter int BurstDataCount  = 4
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       r0_req_i,
    output logic                       r0_gnt_o,
    input  logic                       r0_cmd_i,
    input  logic                       r0_cmd_en_i,
    input  logic [AddressBitWidth-1:0] r0_addr_i,
    input  logic [63:0]                r0_wr_data_i,
    input  logic [7:0]                 r0_data_mask_i,
    output logic [63:0]                r0_rd_data_o,
    output logic                       r0_rd_data_valid_o,

    input  logic                       r1_req_i,
    output logic                       r1_gnt_o,
    input  logic                       r1_cmd_i,
    input  logic                       r1_cmd_en_i,
    input  logic [AddressBitWidth-1:0] r1_addr_i,
    input  logic [63:0]                r1_wr_data_i,
    input  logic [7:0]                 r1_data_mask_i,
    output logic [63:0]                r1_rd_data_o,
    output logic                       r1_rd_data_valid_o,

    output logic                       br_cmd_o,
    output logic                       br_cmd_en_o,
    output logic [AddressBitWidth-1:0] br_addr_o,
    output logic [63:0]                br_wr_data_o,
    output logic [7:0]                 br_data_mask_o,
    input  logic [63:0]                br_rd_data_i,
    input  logic                       br_rd_data_valid_i,
    input  logic                       br_busy_i
);

    localparam int CntW = $clog2(BurstDataCount + 1);
    localparam logic [CntW-1:0] WrLoad = CntW'(BurstDataCount - 1);
    localparam logic [CntW-1:0] RdLoad = CntW'(BurstDataCount);

    logic [NumRequesters-1:0]   req_w;
    logic [NumRequesters-1:0]   cmd_w;
    logic [NumRequesters-1:0]   cmd_en_w;
    logic [NumRequesters-1:0]   rd_valid_w;
    logic [AddressBitWidth-1:0] addr_w    [NumRequesters];
    logic [63:0]                wr_data_w [NumRequesters];
    logic [7:0]                 mask_w    [NumRequesters];

    state_e                   state_q;
    owner_t                   owner_q;
    logic [NumRequesters-1:0] gnt_q;
    logic [CntW-1:0]          cnt_q;
    logic [CntW-1:0]          cnt_dec_d;
    owner_t                   pick_d;
`ifndef BURST_RAM_ARBITER_FIXED_PRIORITY_EN
    owner_t                   rr_last_q;
`endif

    assign req_w        = {r1_req_i, r0_req_i};
    assign cmd_w        = {r1_cmd_i, r0_cmd_i};
    assign cmd_en_w     = {r1_cmd_en_i, r0_cmd_en_i};
    assign addr_w[0]    = r0_addr_i;
    assign addr_w[1]    = r1_addr_i;
    assign wr_data_w[0] = r0_wr_data_i;
    assign wr_data_w[1] = r1_wr_data_i;
    assign mask_w[0]    = r0_data_mask_i;
    assign mask_w[1]    = r1_data_mask_i;

    // Beats only ever reach the current owner, and only while its read is in flight.
    for (genvar gi = 0; gi < NumRequesters; gi++) begin : g_rd_valid
        assign rd_valid_w[gi] = br_rd_data_valid_i && (state_q == READ) && (owner_q == owner_t'(gi));
    end

    assign r0_gnt_o           = gnt_q[0];
    assign r1_gnt_o           = gnt_q[1];
    assign r0_rd_data_o       = br_rd_data_i;
    assign r1_rd_data_o       = br_rd_data_i;
    assign r0_rd_data_valid_o = rd_valid_w[0];
    assign r1_rd_data_valid_o = rd_valid_w[1];

    assign cnt_dec_d = (cnt_q == '0) ? '0 : cnt_q - CntW'(1);

    always_comb begin
        pick_d = owner_t'(0);
        if (req_w[1] && !req_w[0]) begin
            pick_d = owner_t'(1);
        end else if (req_w[1] && req_w[0]) begin
`ifdef BURST_RAM_ARBITER_FIXED_PRIORITY_EN
            pick_d = owner_t'(1);
`else
            pick_d = ~rr_last_q;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= owner_t'(0);
            gnt_q     <= '0;
            cnt_q     <= '0;
`ifndef BURST_RAM_ARBITER_FIXED_PRIORITY_EN
            // Pretend r1 was served last so r0 wins the first tie.
            rr_last_q <= owner_t'(1);
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (!br_busy_i && (req_w != '0)) begin
                        state_q   <= GRANT;
                        owner_q   <= pick_d;
                        gnt_q     <= owner_onehot(pick_d);
`ifndef BURST_RAM_ARBITER_FIXED_PRIORITY_EN
                        rr_last_q <= pick_d;
`endif
                    end
                end
                GRANT: begin
                    if (cmd_en_w[owner_q]) begin
                        if (!cmd_w[owner_q]) begin
                            state_q <= READ;
                            cnt_q   <= RdLoad;
                        end else if (WrLoad == '0) begin
                            state_q <= IDLE;
                            gnt_q   <= '0;
                        end else begin
                            state_q <= WRITE;
                            cnt_q   <= WrLoad;
                        end
                    end else if (!req_w[owner_q]) begin
                        state_q <= IDLE;
                        gnt_q   <= '0;
                    end
                end
                WRITE: begin
                    // The cmd_en cycle already carried beat 0; count the remaining ones.
                    cnt_q <= cnt_dec_d;
                    if (cnt_dec_d == '0) begin
                        state_q <= IDLE;
                        gnt_q   <= '0;
                    end
                end
                READ: begin
                    if (br_rd_data_valid_i) begin
                        cnt_q <= cnt_dec_d;
                        if (cnt_dec_d == '0) begin
                            state_q <= IDLE;
                            gnt_q   <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

    // A command is only accepted in GRANT; stray pulses later in the burst stay off the RAM bus.
    always_comb begin
        br_cmd_o       = 1'b0;
        br_cmd_en_o    = 1'b0;
        br_addr_o      = '0;
        br_wr_data_o   = '0;
        br_data_mask_o = '0;
        if (state_q != IDLE) begin
            br_cmd_o       = cmd_w[owner_q];
            br_cmd_en_o    = cmd_en_w[owner_q] && (state_q == GRANT);
            br_addr_o      = addr_w[owner_q];
            br_wr_data_o   = wr_data_w[owner_q];
            br_data_mask_o = mask_w[owner_q];
        end
    end

endmodule
